// File: rtl/gpu_cmd_dispatcher_if.sv
// Command-FIFO head and draw-engine bundle between the dispatcher
// (master) and the FIFO/engines side (slave).
interface gpu_cmd_dispatcher_if #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int NUM_ENGINES  = 4
);
    logic                    fifo_empty_i;
    logic [3:0]              opcode_i;
    logic [WIDTH_BITS-1:0]   x1_i;
    logic [WIDTH_BITS-1:0]   x2_i;
    logic [HEIGHT_BITS-1:0]  y1_i;
    logic [HEIGHT_BITS-1:0]  y2_i;
    logic [WIDTH_BITS-1:0]   rad_i;
    logic [2:0]              oct_i;
    logic [CHANNEL_BITS-1:0] r_i;
    logic [CHANNEL_BITS-1:0] g_i;
    logic [CHANNEL_BITS-1:0] b_i;
    logic [NUM_ENGINES-1:0]  eng_done_i;

    logic                    pop_o;
    logic [NUM_ENGINES-1:0]  eng_start_o;
    logic [WIDTH_BITS-1:0]   x1_o;
    logic [WIDTH_BITS-1:0]   x2_o;
    logic [HEIGHT_BITS-1:0]  y1_o;
    logic [HEIGHT_BITS-1:0]  y2_o;
    logic [WIDTH_BITS-1:0]   rad_o;
    logic [2:0]              oct_o;
    logic [CHANNEL_BITS-1:0] r_o;
    logic [CHANNEL_BITS-1:0] g_o;
    logic [CHANNEL_BITS-1:0] b_o;

    modport master (
        input  fifo_empty_i, opcode_i,
        input  x1_i, x2_i, y1_i, y2_i,
        input  rad_i, oct_i, r_i, g_i, b_i,
        input  eng_done_i,
        output pop_o, eng_start_o,
        output x1_o, x2_o, y1_o, y2_o,
        output rad_o, oct_o, r_o, g_o, b_o
    );

    modport slave (
        output fifo_empty_i, opcode_i,
        output x1_i, x2_i, y1_i, y2_i,
        output rad_i, oct_i, r_i, g_i, b_i,
        output eng_done_i,
        input  pop_o, eng_start_o,
        input  x1_o, x2_o, y1_o, y2_o,
        input  rad_o, oct_o, r_o, g_o, b_o
    );
endinterface

// File: rtl/gpu_cmd_dispatcher.sv
// Pops one FIFO command at a time, starts the matching draw engine, waits done.
// Define GPU_DISPATCH_TIMEOUT_EN to add the WAIT-state engine watchdog.
module gpu_cmd_dispatcher #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int NUM_ENGINES  = 4,
    parameter int BASE_OPCODE  = 4,
    parameter int FLUSH_OPCODE = 8,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                 clk,
    input  logic                 n_rst,
    gpu_cmd_dispatcher_if.master bus,
    output logic                 flush_frame_o,
    output logic                 busy_o,
    output logic                 err_illegal_o,
    output logic                 timeout_o,
    output logic [15:0]          cmd_count_o
);
    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        START,
        WAIT,
        FLUSH,
        POP
    } state_t;

    state_t state;
    state_t nxt;

    logic [NUM_ENGINES-1:0]  dec_oh;
    logic [NUM_ENGINES-1:0]  sel_oh;
    logic                    is_draw;
    logic                    is_flush;
    logic                    done_hit;
    logic                    expired;
    logic                    err_c;
    logic                    tmo_c;
    logic [15:0]             cmd_cnt;

    logic [WIDTH_BITS-1:0]   x1_q;
    logic [WIDTH_BITS-1:0]   x2_q;
    logic [HEIGHT_BITS-1:0]  y1_q;
    logic [HEIGHT_BITS-1:0]  y2_q;
    logic [WIDTH_BITS-1:0]   rad_q;
    logic [2:0]              oct_q;
    logic [CHANNEL_BITS-1:0] r_q;
    logic [CHANNEL_BITS-1:0] g_q;
    logic [CHANNEL_BITS-1:0] b_q;

    // 5-bit compare keeps BASE_OPCODE+k from aliasing into low opcodes
    always_comb begin
        dec_oh = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            dec_oh[k] = ({1'b0, bus.opcode_i} == 5'(BASE_OPCODE + k));
        end
    end

    assign is_draw  = |dec_oh;
    assign is_flush = (bus.opcode_i == 4'(FLUSH_OPCODE));
    assign done_hit = |(bus.eng_done_i & sel_oh);

`ifdef GPU_DISPATCH_TIMEOUT_EN
    logic [15:0] wait_cnt;

    assign expired = (wait_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= '0;
        end else if (state == START) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYC == 0);
    assign expired    = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt   = state;
        err_c = 1'b0;
        tmo_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.fifo_empty_i) nxt = DECODE;
            end
            DECODE: begin
                if (is_draw) begin
                    nxt = START;
                end else if (is_flush) begin
                    nxt = FLUSH;
                end else begin
                    nxt   = POP;
                    err_c = 1'b1;
                end
            end
            START: nxt = WAIT;
            // a real done in the expiry cycle takes priority
            WAIT: begin
                if (done_hit) begin
                    nxt = POP;
                end else if (expired) begin
                    nxt   = POP;
                    tmo_c = 1'b1;
                end
            end
            FLUSH: nxt = POP;
            POP:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sel_oh  <= '0;
            cmd_cnt <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            rad_q   <= '0;
            oct_q   <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            if (state == DECODE) begin
                sel_oh <= dec_oh;
                x1_q   <= bus.x1_i;
                x2_q   <= bus.x2_i;
                y1_q   <= bus.y1_i;
                y2_q   <= bus.y2_i;
                rad_q  <= bus.rad_i;
                oct_q  <= bus.oct_i;
                r_q    <= bus.r_i;
                g_q    <= bus.g_i;
                b_q    <= bus.b_i;
            end
            if (state == POP) begin
                cmd_cnt <= cmd_cnt + 16'd1;
            end
        end
    end

    assign bus.pop_o       = (state == POP);
    assign bus.eng_start_o = (state == START) ? sel_oh : '0;
    assign bus.x1_o        = x1_q;
    assign bus.x2_o        = x2_q;
    assign bus.y1_o        = y1_q;
    assign bus.y2_o        = y2_q;
    assign bus.rad_o       = rad_q;
    assign bus.oct_o       = oct_q;
    assign bus.r_o         = r_q;
    assign bus.g_o         = g_q;
    assign bus.b_o         = b_q;

    assign flush_frame_o = (state == FLUSH);
    assign busy_o        = (state != IDLE);
    assign err_illegal_o = err_c;
    assign timeout_o     = tmo_c;
    assign cmd_count_o   = cmd_cnt;
endmodule

// File: tb/tb_gpu_cmd_dispatcher.sv
// Bench for gpu_cmd_dispatcher: vector table, corner sequences, random commands.
// Cycle numbers count edges after the command is presented at an idle FIFO.
module tb_gpu_cmd_dispatcher;
    localparam int W  = 10;
    localparam int H  = 9;
    localparam int C  = 8;
    localparam int N  = 4;
    localparam int BO = 4;
    localparam int FO = 8;
    localparam int TO = 16;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] x1, x2, rad;
        logic [H-1:0] y1, y2;
        logic [2:0]   oct;
        logic [C-1:0] r, g, b;
        int           dly;
        logic [N-1:0] dmask;
        logic [N-1:0] e_start;
        int           e_flush;
        int           e_err;
        int           e_pop;
    } vec_t;

    typedef struct {
        int           start_cyc;
        logic [N-1:0] start_val;
        int           start_n;
        int           flush_cyc;
        int           flush_n;
        int           err_cyc;
        int           err_n;
        int           tmo_cyc;
        int           tmo_n;
        int           pop_cyc;
        int           pop_n;
        bit           opnd_ok;
        bit           busy_ok;
        bit           idle_after;
        logic [15:0]  count;
    } res_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        flush_frame;
    logic        busy;
    logic        err_illegal;
    logic        timeout;
    logic [15:0] cmd_count;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_count = '0;

    gpu_cmd_dispatcher_if #(
        .WIDTH_BITS(W), .HEIGHT_BITS(H),
        .CHANNEL_BITS(C), .NUM_ENGINES(N)
    ) bus ();

    gpu_cmd_dispatcher #(
        .WIDTH_BITS(W), .HEIGHT_BITS(H), .CHANNEL_BITS(C),
        .NUM_ENGINES(N), .BASE_OPCODE(BO), .FLUSH_OPCODE(FO),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus),
        .flush_frame_o(flush_frame),
        .busy_o(busy),
        .err_illegal_o(err_illegal),
        .timeout_o(timeout),
        .cmd_count_o(cmd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input int dly,
                                input logic [N-1:0] dm, input logic [N-1:0] es,
                                input int ef, input int ee, input int ep);
        vec_t v;
        v.op = op; v.dly = dly; v.dmask = dm;
        v.x1 = W'($urandom); v.x2 = W'($urandom); v.rad = W'($urandom);
        v.y1 = H'($urandom); v.y2 = H'($urandom); v.oct = 3'($urandom);
        v.r = C'($urandom); v.g = C'($urandom); v.b = C'($urandom);
        v.e_start = es; v.e_flush = ef; v.e_err = ee; v.e_pop = ep;
        return v;
    endfunction

    // Spec-level outcome of one command: which pulse, at which cycle
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        logic [N-1:0] one = 1;
        int o = int'(v.op);
        m.e_start = '0; m.e_flush = -1; m.e_err = -1;
        if (o >= BO && o < BO + N) begin
            m.e_start = one << (o - BO);
            m.e_pop   = 3 + v.dly;
        end else if (o == FO) begin
            m.e_flush = 2;
            m.e_pop   = 3;
        end else begin
            m.e_err = 1;
            m.e_pop = 2;
        end
        return m;
    endfunction

    task automatic drive_head(input vec_t v);
        bus.opcode_i = v.op;
        bus.x1_i = v.x1; bus.x2_i = v.x2; bus.rad_i = v.rad;
        bus.y1_i = v.y1; bus.y2_i = v.y2; bus.oct_i = v.oct;
        bus.r_i = v.r; bus.g_i = v.g; bus.b_i = v.b;
    endtask

    function automatic bit opnd_match(input vec_t v);
        return bus.x1_o == v.x1 && bus.x2_o == v.x2 &&
               bus.y1_o == v.y1 && bus.y2_o == v.y2 &&
               bus.rad_o == v.rad && bus.oct_o == v.oct &&
               bus.r_o == v.r && bus.g_o == v.g && bus.b_o == v.b;
    endfunction

    task automatic exec_cmd(input vec_t v, input int limit,
                            input bit noise, output res_t r);
        bit seen = 0;
        r.start_cyc = -1; r.start_val = '0; r.start_n = 0;
        r.flush_cyc = -1; r.flush_n = 0; r.err_cyc = -1; r.err_n = 0;
        r.tmo_cyc = -1; r.tmo_n = 0; r.pop_cyc = -1; r.pop_n = 0;
        r.opnd_ok = 1; r.busy_ok = 1;
        drive_head(v);
        bus.fifo_empty_i = 1'b0;
        for (int c = 1; c <= limit && !seen; c++) begin
            @(posedge clk); #1;
            bus.eng_done_i = '0;
            if (c == 2) drive_head(mk(4'($urandom), 0, '0, '0, 0, 0, 0));
            if (bus.eng_start_o != '0) begin
                r.start_n++;
                if (r.start_cyc < 0) begin
                    r.start_cyc = c;
                    r.start_val = bus.eng_start_o;
                end
            end
            if (flush_frame) begin
                r.flush_n++;
                if (r.flush_cyc < 0) r.flush_cyc = c;
            end
            if (err_illegal) begin
                r.err_n++;
                if (r.err_cyc < 0) r.err_cyc = c;
            end
            if (timeout) begin
                r.tmo_n++;
                if (r.tmo_cyc < 0) r.tmo_cyc = c;
            end
            if (c >= 2 && !opnd_match(v)) r.opnd_ok = 0;
            if (!busy) r.busy_ok = 0;
            if (bus.pop_o) begin
                r.pop_n++;
                r.pop_cyc = c;
                seen = 1;
                bus.fifo_empty_i = 1'b1;
            end else if (r.start_cyc > 0) begin
                if (v.dly > 0 && c == r.start_cyc + v.dly)
                    bus.eng_done_i = v.dmask;
                else if (noise && c == r.start_cyc)
                    bus.eng_done_i = N'($urandom);
                else if (noise)
                    bus.eng_done_i = N'($urandom) & ~r.start_val;
            end
        end
        bus.fifo_empty_i = 1'b1;
        @(posedge clk); #1;
        bus.eng_done_i = '0;
        if (bus.pop_o) r.pop_n++;
        r.idle_after = !busy;
        r.count = cmd_count;
    endtask

    task automatic check_res(input string t, input res_t r, input vec_t e,
                             input int e_tmo);
        chk({t, " start_val"}, r.start_val, e.e_start);
        chk({t, " start_n"}, r.start_n, (e.e_start != '0) ? 1 : 0);
        chk({t, " start_cyc"}, r.start_cyc, (e.e_start != '0) ? 2 : -1);
        chk({t, " flush_cyc"}, r.flush_cyc, e.e_flush);
        chk({t, " flush_n"}, r.flush_n, (e.e_flush >= 0) ? 1 : 0);
        chk({t, " err_cyc"}, r.err_cyc, e.e_err);
        chk({t, " err_n"}, r.err_n, (e.e_err >= 0) ? 1 : 0);
        chk({t, " tmo_cyc"}, r.tmo_cyc, e_tmo);
        chk({t, " pop_cyc"}, r.pop_cyc, e.e_pop);
        chk({t, " pop_n"}, r.pop_n, (e.e_pop >= 0) ? 1 : 0);
        chk({t, " operands"}, r.opnd_ok, 1);
        chk({t, " busy"}, r.busy_ok, 1);
        chk({t, " idle_after"}, r.idle_after, e.e_pop >= 0);
        chk({t, " count"}, r.count, exp_count);
    endtask

    vec_t tv[8];
    vec_t v;
    res_t r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = mk(4'h4, 6, 4'b0001, 4'b0001, -1, -1, 9);
        tv[0].x1 = 10; tv[0].y1 = 20; tv[0].x2 = 30; tv[0].y2 = 40;
        tv[1] = mk(4'h7, 3, 4'b1001, 4'b1000, -1, -1, 6);
        tv[2] = mk(4'h8, 0, 4'b0000, 4'b0000,  2, -1, 3);
        tv[3] = mk(4'hF, 0, 4'b0000, 4'b0000, -1,  1, 2);
        tv[4] = mk(4'h5, 1, 4'b0010, 4'b0010, -1, -1, 4);
        tv[5] = mk(4'h6, 4, 4'b1111, 4'b0100, -1, -1, 7);
        tv[6] = mk(4'h0, 0, 4'b0000, 4'b0000, -1,  1, 2);
        tv[7] = mk(4'h3, 0, 4'b0000, 4'b0000, -1,  1, 2);

        // reset held with a non-empty FIFO
        n_rst = 1'b0;
        bus.fifo_empty_i = 1'b0;
        bus.eng_done_i = '0;
        drive_head(tv[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("rst pop", bus.pop_o, 0);
        chk("rst start", bus.eng_start_o, 0);
        chk("rst flush", flush_frame, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err_illegal, 0);
        chk("rst timeout", timeout, 0);
        chk("rst count", cmd_count, 0);
        chk("rst x1", bus.x1_o, 0);
        chk("rst b", bus.b_o, 0);
        n_rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            exec_cmd(tv[i], 40, i >= 4, r);
            exp_count++;
            check_res($sformatf("vec%0d", i), r, tv[i], -1);
        end

`ifdef GPU_DISPATCH_TIMEOUT_EN
        v = mk(4'h5, 0, '0, 4'b0010, -1, -1, 3 + TO);
        exec_cmd(v, 40, 0, r);
        exp_count++;
        check_res("timeout", r, v, 2 + TO);
        chk("timeout n", r.tmo_n, 1);
        v = mk(4'h5, TO, 4'b0010, 4'b0010, -1, -1, 3 + TO);
        exec_cmd(v, 40, 0, r);
        exp_count++;
        check_res("done_wins", r, v, -1);
        v = mk(4'h6, 0, '0, 4'b0100, -1, -1, -1);
        exec_cmd(v, 8, 0, r);
        check_res("wait_short", r, v, -1);
`else
        v = mk(4'h5, 0, '0, 4'b0010, -1, -1, -1);
        exec_cmd(v, 100, 1, r);
        check_res("hang", r, v, -1);
`endif

        // reset while stuck in WAIT
        n_rst = 1'b0;
        #1;
        chk("wrst busy", busy, 0);
        chk("wrst pop", bus.pop_o, 0);
        chk("wrst start", bus.eng_start_o, 0);
        chk("wrst count", cmd_count, 0);
        chk("wrst x1", bus.x1_o, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        exp_count = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("wrst idle", busy || bus.pop_o || flush_frame, 0);
        end

        // count wrap from preloaded 0xFFFE
        force dut.cmd_cnt = 16'hFFFE;
        #1;
        release dut.cmd_cnt;
        exp_count = 16'hFFFE;
        v = model(mk(4'(FO), 0, '0, '0, 0, 0, 0));
        exec_cmd(v, 40, 0, r);
        exp_count++;
        check_res("wrap_ffff", r, v, -1);
        v = model(mk(4'hE, 0, '0, '0, 0, 0, 0));
        exec_cmd(v, 40, 0, r);
        exp_count++;
        check_res("wrap_0", r, v, -1);
        chk("wrap value", r.count, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            if ($urandom_range(0, 1) == 1)
                op = 4'(BO + $urandom_range(0, N - 1));
            else
                op = 4'($urandom_range(0, 15));
            v = mk(op, $urandom_range(1, 8), '0, '0, 0, 0, 0);
            v = model(v);
            v.dmask = v.e_start | N'($urandom);
            exec_cmd(v, 40, 1, r);
            exp_count++;
            check_res($sformatf("rnd%0d", i), r, v, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
